// File: rtl/accumulator_ctrl.sv
// Streaming accumulator: sums a packet of 32-bit terms through a ripple adder and
// hands out total, count and sticky overflow. Define ACC_SATURATE_EN to clamp at max.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] carry;

    always_comb begin
        carry = '0;
        for (int i = 0; i < 31; i++) begin
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        sum = a ^ b ^ carry;
    end
endmodule

// state | meaning
// ACC   | accepting terms, in_ready high
// DONE  | holding packet result, out_valid high
module accumulator_ctrl #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);
    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          acc_q, acc_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          sum;
    logic                 carry_out;

    adder u_adder (
        .a   (acc_q),
        .b   (in_data),
        .sum (sum)
    );

    // The adder has no carry-out; a wrapped sum is always smaller than acc.
    assign carry_out = (sum < acc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ACC_SATURATE_EN
                    acc_d = carry_out ? 32'hFFFF_FFFF : sum;
`else
                    acc_d = sum;
`endif
                    if (cnt_q != {COUNT_W{1'b1}}) begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                    ovf_d = ovf_q | carry_out;
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_accumulator_ctrl.sv
// Directed and randomised checks for accumulator_ctrl; the second instance
// uses a 2-bit counter to reach count saturation quickly.

module tb_accumulator_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_sum;
    logic [7:0]  out_count;

    logic        in_valid1 = 1'b0, in_last1 = 1'b0, out_ready1 = 1'b0;
    logic [31:0] in_data1 = '0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_sum1;
    logic [1:0]  out_count1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    accumulator_ctrl #(.COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    accumulator_ctrl #(.COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_count(out_count1), .out_ovf(out_ovf1)
    );

    // Offer one term from a falling edge until the DUT takes it; waits = stall cycles.
    task automatic send_beat(input logic [31:0] d, input logic last, output int waits);
        logic took;
        waits = 0;
        took  = 1'b0;
        while (!took && waits < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            took     = in_ready;
            @(posedge clk);
            if (!took) waits++;
        end
        if (!took) begin
            tests++; fails++;
            $display("FAIL send_beat timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (out_valid) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_done timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        logic ok;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'd0 ||
            out_count !== 8'd0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_init: rdy=%0b vld=%0b sum=%0d cnt=%0d ovf=%0b required 1 0 0 0 0",
                     in_ready, out_valid, out_sum, out_count, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(32'd5, 1'b0, w);
        send_beat(32'd7, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_sum !== 32'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_packet: sum=%0d rdy=%0b vld=%0b cnt=%0d required 0 1 0 0",
                     out_sum, in_ready, out_valid, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(32'd1, 1'b1, w);
        wait_done(ok);
        if (ok) begin
            tests++;
            if (out_sum !== 32'd1 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
                fails++;
                $display("FAIL reset_next_packet: sum=%0d cnt=%0d ovf=%0b required 1 1 0",
                         out_sum, out_count, out_ovf);
            end
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int w;
        logic [31:0] terms [3] = '{32'd10, 32'd20, 32'd30};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_beat(terms[i], i == 2, w);
            tests++;
            if (w !== 0) begin
                fails++;
                $display("FAIL b2b_throughput beat %0d: stalls=%0d required 0", i, w);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'd60 ||
            out_count !== 8'd3 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL b2b_result: vld=%0b rdy=%0b sum=%0d cnt=%0d ovf=%0b required 1 0 60 3 0",
                     out_valid, in_ready, out_sum, out_count, out_ovf);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_release: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int w;
        logic ok;
        out_ready = 1'b0;
        send_beat(32'h0000_FFFF, 1'b0, w);
        send_beat(32'd1, 1'b1, w);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h55;
            in_last  = 1'b1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h0001_0000 ||
                out_count !== 8'd2) begin
                fails++;
                $display("FAIL backpressure cycle %0d: vld=%0b rdy=%0b sum=%h cnt=%0d required 1 0 00010000 2",
                         k, out_valid, in_ready, out_sum, out_count);
            end
            out_ready = (k == 5);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        send_beat(32'd2, 1'b1, w);
        wait_done(ok);
        if (ok) begin
            tests++;
            if (out_sum !== 32'd2 || out_count !== 8'd1) begin
                fails++;
                $display("FAIL backpressure_not_consumed: sum=%0d cnt=%0d required 2 1", out_sum, out_count);
            end
        end
        release_result();
    endtask

    task automatic test_overflow();
        int w;
        logic ok;
        logic [31:0] exp_sum;
`ifdef ACC_SATURATE_EN
        exp_sum = 32'hFFFF_FFFF;
`else
        exp_sum = 32'h0000_0010;
`endif
        send_beat(32'hFFFF_FFF0, 1'b0, w);
        send_beat(32'h20, 1'b1, w);
        wait_done(ok);
        if (ok) begin
            tests++;
            if (out_ovf !== 1'b1 || out_sum !== exp_sum || out_count !== 8'd2) begin
                fails++;
                $display("FAIL overflow: ovf=%0b sum=%h cnt=%0d required 1 %h 2",
                         out_ovf, out_sum, out_count, exp_sum);
            end
        end
        release_result();
        send_beat(32'd3, 1'b1, w);
        wait_done(ok);
        if (ok) begin
            tests++;
            if (out_ovf !== 1'b0 || out_sum !== 32'd3 || out_count !== 8'd1) begin
                fails++;
                $display("FAIL overflow_cleared: ovf=%0b sum=%0d cnt=%0d required 0 3 1",
                         out_ovf, out_sum, out_count);
            end
        end
        release_result();
    endtask

    task automatic test_count_sat();
        int n = 0;
        int k = 0;
        out_ready1 = 1'b0;
        while (n < 5 && k < 100) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            in_data1  = 32'd1;
            in_last1  = (n == 4);
            if (in_ready1) n++;
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        tests++;
        if (out_valid1 !== 1'b1 || out_count1 !== 2'd3 || out_sum1 !== 32'd5) begin
            fails++;
            $display("FAIL count_saturate: vld=%0b cnt=%0d sum=%0d required 1 3 5",
                     out_valid1, out_count1, out_sum1);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
    endtask

    task automatic test_random();
        int w, nterms, guard;
        logic [32:0] t;
        logic [31:0] m_acc, d;
        logic        m_ovf, done, checked;
        for (int p = 0; p < 1000; p++) begin
            nterms = $urandom_range(1, 4);
            m_acc  = '0;
            m_ovf  = 1'b0;
            for (int i = 0; i < nterms; i++) begin
                d = ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | $urandom) : $urandom;
                if ($urandom_range(0, 7) == 0) d = '0;
                t = {1'b0, m_acc} + {1'b0, d};
                if (t[32]) m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
                m_acc = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
                m_acc = t[31:0];
`endif
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
                send_beat(d, i == nterms - 1, w);
            end
            done    = 1'b0;
            checked = 1'b0;
            guard   = 0;
            while (!done && guard < 100) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_last   = 1'b0;
                out_ready = ($urandom_range(0, 1) == 1);
                if (out_valid && !checked) begin
                    checked = 1'b1;
                    tests++;
                    if (out_sum !== m_acc || out_ovf !== m_ovf || out_count !== 8'(nterms)) begin
                        fails++;
                        $display("FAIL random pkt %0d: sum=%h ovf=%0b cnt=%0d required %h %0b %0d",
                                 p, out_sum, out_ovf, out_count, m_acc, m_ovf, nterms);
                    end
                end
                if (out_valid && out_ready) done = 1'b1;
                @(posedge clk);
                guard++;
            end
            if (!done) begin
                tests++; fails++;
                $display("FAIL random pkt %0d timeout: out_valid=%0b required release", p, out_valid);
            end
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_count_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequential accumulation stage built around the team's 32-bit combinational `adder`. It accepts a stream of 32-bit unsigned terms over a valid/ready handshake and feeds each term, together with the running total, into an internal `adder` instance. It registers the `adder` sum back into the accumulator. When the last term of a packet is accepted, it presents the total, the term count and a sticky overflow flag on an output valid/ready handshake.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the term counter; the count saturates at 2^COUNT_W-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  a term is offered.
- `in_ready`  out  1  the block can accept a term.
- `in_data`  in  32  unsigned term.
- `in_last`  in  1  the offered term is the final one of the packet.
- `out_valid`  out  1  a result is held.
- `out_ready`  in  1  the consumer takes the result.
- `out_sum`  out  32  accumulated total.
- `out_count`  out  COUNT_W  number of terms accepted in the packet, saturating.
- `out_ovf`  out  1  sticky unsigned overflow flag.

## Operation
- Datapath: one internal `adder` instance with `a` = `acc` and `b` = `in_data`. Its `sum` is the next accumulator value. No other adder or `+` operator is used on the 32-bit path.
- Overflow detection: the `adder` exposes no carry-out. A carry out of bit 31 is therefore detected as `sum < acc` (unsigned compare).
- Registers: `acc` (32), `cnt` (COUNT_W), `ovf` (1), `state`.
- State ACC:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`: `acc` takes the adder sum, `cnt` increments (holds at max), and `ovf` is set if an overflow is detected (`ovf` never clears within a packet).
  - If `in_last` is also high, go to DONE.
- State DONE:
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`=`acc`, `out_count`=`cnt`, `out_ovf`=`ovf`; these are stable while `out_valid` is high.
  - On `out_ready`: clear `acc`, `cnt` and `ovf` to 0 and return to ACC.
- Outputs are driven directly from registers and the state; there is no combinational path from `in_*` to `out_*`.
- Single-term packet (`in_last` on the first beat): the result is that term, with count 1.
- Term with `in_data`=0: counted normally; `acc` unchanged.
- `in_valid` low in ACC: no state change; a packet may stall indefinitely.
- `out_ready` high while in ACC: ignored.

## Timing
- Reset: `state`=ACC, `acc`=0, `cnt`=0, `ovf`=0. Therefore `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0, taking effect immediately on `rst_n` falling.
- Throughput: one term per cycle within a packet.
- Latency: if the last term is accepted at edge N, `out_valid` is high in the cycle after N.
- Output release: if `out_ready` is high at edge M, `in_ready` is 1 in the cycle after M. Minimum gap between packets: one cycle (the DONE cycle).
- Reset asserted mid-packet or while in DONE: the partial total and any held result are discarded, and the block returns to the reset values above.
- The `adder` is a ripple chain; `clk` period must cover the 32-bit carry path plus the compare.

## Configuration
- `ACC_SATURATE_EN` defined:
  - On a detected overflow, `acc` is loaded with 32'hFFFF_FFFF instead of the wrapped sum, and `ovf` is set.
  - Subsequent terms leave `acc` at max.
- `ACC_SATURATE_EN` undefined:
  - `acc` takes the wrapped (mod 2^32) sum.
  - `ovf` is still set and sticky.

## Test plan
- Reset: drive `rst_n`=0 mid-packet after terms 5 and 7 -> `acc`=0, `in_ready`=1, `out_valid`=0. A following packet {1 last} -> `out_sum`=1, `out_count`=1.
- Back-to-back stream: terms 10, 20, 30 (last), `out_ready` held high -> one term per cycle. `out_valid` is high for exactly one cycle, with `out_sum`=60, `out_count`=3, `out_ovf`=0. `in_ready` returns the cycle after.
- Backpressure: packet {0xFFFF, 1 last} with `out_ready`=0 for 5 cycles -> `out_sum`=0x10000 stable for all 6 cycles, `in_ready`=0 throughout, and an `in_valid` offered meanwhile is not consumed.
- Overflow: packet {0xFFFF_FFF0, 0x20 last} -> `out_ovf`=1. `out_sum`=0x10 without the macro, 0xFFFF_FFFF with `ACC_SATURATE_EN`. A next packet {3 last} -> `out_ovf`=0, `out_sum`=3.
- Count saturation (`COUNT_W`=2): a packet of five terms of value 1 -> `out_count`=3, `out_sum`=5.
- Random stalls: random `in_valid`/`out_ready` over 1000 packets -> each result matches the scoreboard sum mod 2^32 and the carry-out flag.
